// File: rtl/hex_disp_pkg.sv
// Shared types for the hex display arbiter.
// State encoding and display byte width.
package hex_disp_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } disp_state_e;

endpackage

// File: rtl/hex_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester
// at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] w_k;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      w_k   = '0;
      for (int i = 0; i < N; i++) begin
         w_k = IW'((int'(ptr) + i) % N);
         if (!found && req[w_k]) begin
            found = 1'b1;
            idx   = w_k;
         end
      end
   end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the shared two-digit hex display.
// Each grant lasts DWELL cycles or until the owner withdraws.
module hex_display_arbiter
   import hex_disp_pkg::*;
#(
   parameter int N     = 4,
   parameter int DWELL = 25_000_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              req,
   input  logic [N-1:0][BYTE_W-1:0]  value,
   output logic [BYTE_W-1:0]         num,
   output logic                      num_valid,
   output logic [N-1:0]              grant,
   output logic [$clog2(N)-1:0]      owner,
   output logic [N-1:0]              done
);

   localparam int OW = $clog2(N);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
   localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

   disp_state_e       r_state, w_state_nx;
   logic [OW-1:0]     r_ptr, w_ptr_nx;
   logic [OW-1:0]     r_owner, w_owner_nx;
   logic [CW-1:0]     r_cnt, w_cnt_nx;
   logic [N-1:0]      r_grant, w_grant_nx;
   logic [BYTE_W-1:0] r_num, w_num_nx;
   logic              r_valid, w_valid_nx;

   logic [OW-1:0]     w_owner_inc;
   logic [OW-1:0]     w_pick_ptr;
   logic [OW-1:0]     w_idx;
   logic              w_found;
   logic              w_expire;
   logic              w_withdraw;
   logic              w_end;
   logic              w_arb;

   assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
   assign w_expire    = (r_cnt == LAST_CNT);
   assign w_withdraw  = ~req[r_owner];
   assign w_end       = (r_state == SHOW) & (w_expire | w_withdraw);
   assign w_arb       = (r_state == IDLE) | w_end;

   // A finishing grant searches from the port after its owner
   // in the same edge, so owners hand over without a gap.
   assign w_pick_ptr  = w_end ? w_owner_inc : r_ptr;

   rr_pick #(
      .N(N)
   ) u_pick (
      .req  (req),
      .ptr  (w_pick_ptr),
      .found(w_found),
      .idx  (w_idx)
   );

   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_owner_nx = r_owner;
      w_cnt_nx   = r_cnt;
      w_grant_nx = r_grant;
      w_num_nx   = r_num;
      w_valid_nx = r_valid;

      if (w_end) begin
         w_ptr_nx = w_owner_inc;
      end

      if (w_arb) begin
         w_cnt_nx = '0;
         if (w_found) begin
            w_state_nx = SHOW;
            w_owner_nx = w_idx;
            w_grant_nx = N'(1) << w_idx;
            w_num_nx   = value[w_idx];
            w_valid_nx = 1'b1;
         end else begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
            w_num_nx   = '0;
            w_valid_nx = 1'b0;
         end
      end else if (r_state == SHOW) begin
         w_num_nx = value[r_owner];
         w_cnt_nx = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_grant <= '0;
         r_num   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_owner <= w_owner_nx;
         r_cnt   <= w_cnt_nx;
         r_grant <= w_grant_nx;
         r_num   <= w_num_nx;
         r_valid <= w_valid_nx;
      end
   end

   assign num       = r_num;
   assign num_valid = r_valid;
   assign grant     = r_grant;
   assign owner     = r_owner;
   assign done      = r_grant & {N{w_expire}};

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: vector table, directed
// corner sequences and randomized run against a model.
module tb_hex_display_arbiter;

   localparam int N     = 4;
   localparam int DWELL = 4;

   logic            clk;
   logic            reset;
   logic [3:0]      req;
   logic [3:0][7:0] value;
   logic [7:0]      num;
   logic            num_valid;
   logic [3:0]      grant;
   logic [1:0]      owner;
   logic [3:0]      done;

   int checks;
   int errors;

   hex_display_arbiter #(
      .N(N),
      .DWELL(DWELL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .value    (value),
      .num      (num),
      .num_valid(num_valid),
      .grant    (grant),
      .owner    (owner),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: who is showing and how many cycles it has shown
   bit m_busy;
   int m_owner;
   int m_age;
   int m_ptr;
   int m_num;

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_age   = 0;
      m_ptr   = 0;
      m_num   = 0;
   endtask

   task automatic model_edge(input logic [3:0] rq,
                             input logic [3:0][7:0] vl);
      bit pick;
      int w;
      pick = !m_busy;
      if (m_busy) begin
         if (m_age == DWELL - 1 || !rq[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            pick  = 1;
         end else begin
            m_age = m_age + 1;
            m_num = vl[m_owner];
         end
      end
      if (pick) begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && rq[(m_ptr + i) % N])
               w = (m_ptr + i) % N;
         if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
            m_age   = 0;
            m_num   = vl[w];
         end else begin
            m_busy = 0;
            m_num  = 0;
         end
      end
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h",
                  name, $time, act, exp);
      end
   endtask

   task automatic chk_model();
      logic [31:0] eg;
      logic [31:0] ed;
      eg = m_busy ? (32'd1 << m_owner) : 32'd0;
      ed = (m_busy && m_age == DWELL - 1) ? eg : 32'd0;
      chk("mdl_grant", {28'd0, grant}, eg);
      chk("mdl_owner", {30'd0, owner}, m_owner);
      chk("mdl_num", {24'd0, num}, m_num);
      chk("mdl_valid", {31'd0, num_valid}, {31'd0, m_busy});
      chk("mdl_done", {28'd0, done}, ed);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(req, value);
      #1;
      chk_model();
   endtask

   // called at posedge+1; asynchronous pulse between edges
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_grant", {28'd0, grant}, 0);
      chk("rst_num", {24'd0, num}, 0);
      chk("rst_valid", {31'd0, num_valid}, 0);
      chk("rst_done", {28'd0, done}, 0);
      model_reset();
      #2 reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] owner;
      logic [7:0] num;
      logic [3:0] done;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int dsaw;
      tbl = '{
         '{4'hf, 4'b0001, 2'd0, 8'h10, 4'b0000},
         '{4'hf, 4'b0001, 2'd0, 8'h10, 4'b0000},
         '{4'hf, 4'b0001, 2'd0, 8'h10, 4'b0000},
         '{4'hf, 4'b0001, 2'd0, 8'h10, 4'b0001},
         '{4'hf, 4'b0010, 2'd1, 8'h21, 4'b0000},
         '{4'hf, 4'b0010, 2'd1, 8'h21, 4'b0000},
         '{4'hf, 4'b0010, 2'd1, 8'h21, 4'b0000},
         '{4'hf, 4'b0010, 2'd1, 8'h21, 4'b0010},
         '{4'hf, 4'b0100, 2'd2, 8'h32, 4'b0000},
         '{4'hf, 4'b0100, 2'd2, 8'h32, 4'b0000},
         '{4'hf, 4'b0100, 2'd2, 8'h32, 4'b0000},
         '{4'hf, 4'b0100, 2'd2, 8'h32, 4'b0100},
         '{4'hf, 4'b1000, 2'd3, 8'h43, 4'b0000},
         '{4'hf, 4'b1000, 2'd3, 8'h43, 4'b0000},
         '{4'hf, 4'b1000, 2'd3, 8'h43, 4'b0000},
         '{4'hf, 4'b1000, 2'd3, 8'h43, 4'b1000},
         '{4'hf, 4'b0001, 2'd0, 8'h10, 4'b0000}
      };
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      req    = '0;
      value  = '0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk("init_grant", {28'd0, grant}, 0);
      chk("init_owner", {30'd0, owner}, 0);
      chk("init_num", {24'd0, num}, 0);
      chk("init_valid", {31'd0, num_valid}, 0);
      chk("init_done", {28'd0, done}, 0);
      reset = 1'b0;

      // all four ports requesting
      value[0] = 8'h10;
      value[1] = 8'h21;
      value[2] = 8'h32;
      value[3] = 8'h43;
      foreach (tbl[i]) begin
         req = tbl[i].req;
         step();
         chk("tbl_grant", {28'd0, grant}, {28'd0, tbl[i].grant});
         chk("tbl_owner", {30'd0, owner}, {30'd0, tbl[i].owner});
         chk("tbl_num", {24'd0, num}, {24'd0, tbl[i].num});
         chk("tbl_valid", {31'd0, num_valid}, 1);
         chk("tbl_done", {28'd0, done}, {28'd0, tbl[i].done});
      end

      // reset mid-grant, then lowest requester wins
      pulse_reset();
      req = 4'b0110;
      step();
      chk("post_rst_owner", {30'd0, owner}, 1);
      chk("post_rst_grant", {28'd0, grant}, 4'b0010);

      // sole requester re-granted back to back
      pulse_reset();
      req      = 4'b0001;
      value[0] = 8'h3c;
      for (int c = 1; c <= 12; c++) begin
         step();
         chk("solo_grant", {28'd0, grant}, 4'b0001);
         chk("solo_num", {24'd0, num}, 8'h3c);
         chk("solo_valid", {31'd0, num_valid}, 1);
         chk("solo_done", {28'd0, done}, (c % 4 == 0) ? 1 : 0);
      end

      // withdrawal hands over immediately without done
      pulse_reset();
      req  = 4'b0101;
      dsaw = 0;
      step();
      chk("wd_owner0", {30'd0, owner}, 0);
      dsaw += done[0];
      step();
      dsaw += done[0];
      req = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         step();
         dsaw += done[0];
         chk("wd_owner2", {30'd0, owner}, 2);
         chk("wd_grant2", {28'd0, grant}, 4'b0100);
         chk("wd_done2", {28'd0, done}, (c == 3) ? 4'b0100 : 0);
      end
      chk("wd_no_done0", dsaw, 0);

      // live value update, idle, pointer kept across idle
      pulse_reset();
      req      = 4'b0010;
      value[1] = 8'h12;
      step();
      chk("live_owner", {30'd0, owner}, 1);
      chk("live_num0", {24'd0, num}, 8'h12);
      value[1] = 8'h7f;
      step();
      chk("live_num1", {24'd0, num}, 8'h7f);
      req = 4'b0000;
      step();
      chk("idle_valid", {31'd0, num_valid}, 0);
      chk("idle_num", {24'd0, num}, 0);
      chk("idle_grant", {28'd0, grant}, 0);
      chk("idle_owner", {30'd0, owner}, 1);
      req = 4'b0011;
      step();
      chk("wrap_owner", {30'd0, owner}, 0);
      chk("wrap_grant", {28'd0, grant}, 4'b0001);

      // randomized traffic against the reference
      pulse_reset();
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0)
               req[b] = ~req[b];
         if ($urandom_range(0, 3) == 0)
            value[$urandom_range(0, 3)] = 8'($urandom);
         if ($urandom_range(0, 199) == 0)
            pulse_reset();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Round-robin scheduler that shares the board's single two-digit hexadecimal display between N requesters. Each requester presents an 8-bit value and a request. The arbiter grants the display to one requester for a fixed dwell period, then rotates to the next requester. The registered `num` / `num_valid` outputs feed the existing two-digit seven-segment decoder. The `grant`, `owner` and `done` outputs let requesters (RAM address/data viewers, FIFO status, etc.) know when they are on screen.

## Interface
- `N`, default 4: number of requesters, ≥2.
- `DWELL`, default 25_000_000: cycles per grant (0.5 s at 50 MHz), ≥1. Benches use 4.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N: request per port, level-sensitive.
- `value`  in  N×8 (packed `[N-1:0][7:0]`): value each port wants displayed.
- `num`  out  8: value to display, feeds the decoder's `num`.
- `num_valid`  out  1: display owned. When low, the top level blanks the HEX digits.
- `grant`  out  N: one-hot current owner; all zeros when idle.
- `owner`  out  `$clog2(N)`: index of current owner; holds last owner when idle.
- `done`  out  N: one-cycle pulse on the owner's bit during the final dwell cycle.

## Operation
- FSM states:
  - `IDLE`: no owner.
  - `SHOW`: `grant[owner]`=1.
- Arbitration runs on any edge where the state is `IDLE`, or the state is `SHOW` and the grant ends.
  - Search starts at `ptr` and wraps modulo N. The first port with `req`=1 wins.
  - If there is a winner: enter `SHOW`, `owner`←winner, `grant`←onehot(winner), `num`←`value[winner]`, `cnt`←0.
  - If there is none: enter `IDLE`, `grant`←0, `num`←0, `num_valid`←0.
- In `SHOW`, each edge:
  - `num`←`value[owner]`, a live update.
  - `cnt` increments.
- A grant ends on the edge where either condition holds:
  - `cnt`==DWELL-1 (expiry), or
  - `req[owner]`==0 (withdrawal).
- On grant end, `ptr`←(owner+1) mod N. Arbitration happens in the same edge, so there is no idle gap between owners.
- A sole continuously-requesting port is re-granted back-to-back: `grant` stays high and `cnt` restarts.
- `done[i]` = `grant[i]` & (`cnt`==DWELL-1). It is derived from registers only, with no combinational path from `req`.
- Simultaneous expiry and withdrawal count as a withdrawal: `done` still pulses (from registers), and the port is not re-granted unless another arbitration picks it.
- `DWELL`=1: every grant lasts one cycle, and `done` is high for the whole grant.
- `ptr` survives `IDLE`: after all requests drop, the next arbitration starts after the last owner.

## Timing
- Reset, applied asynchronously and effective immediately mid-operation:
  - state=`IDLE`, `ptr`=0, `cnt`=0, `owner`=0.
  - `grant`=0, `num`=0, `num_valid`=0, `done`=0.
- Request latency: `req` high before edge k gives `grant`/`num_valid`/`num` valid after edge k, i.e. 1 cycle.
- Value latency: a change of `value[owner]` appears on `num` 1 cycle later.
- Grant length: exactly DWELL cycles if uninterrupted. Withdrawal seen at edge k releases at edge k.
- `cnt` width is `$clog2(DWELL)` with a minimum of 1 bit. It never exceeds DWELL-1.
- All outputs are registered or derived from registers only.

## Structure
- Package `hex_disp_pkg` holds:
  - `disp_state_e` enum (`IDLE`, `SHOW`).
  - `BYTE_W`=8.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `found`, `idx`.
  - Parameterised by N, so it can be reused by later arbiters.
- Top-level integration: `hex_display_arbiter.num` → decoder `num`. HEX outputs are forced to all-ones (blank) when `num_valid`=0.

## Test plan
All scenarios use N=4, DWELL=4.
- Reset behaviour: pulse `reset` mid-`SHOW` between clock edges → `grant`=0, `num`=0, `num_valid`=0 immediately. First grant after reset goes to the lowest requesting port.
- Single requester: `req`=0001, `value[0]`=0x3C, held.
  - `grant`=0001 continuously, `num`=0x3C.
  - `done[0]` pulses every 4th cycle.
  - No gap in `num_valid`.
- All ports requesting: `req`=1111, values 0x10/0x21/0x32/0x43.
  - `owner` sequence 0,1,2,3,0, each for 4 cycles.
  - `num` follows that sequence.
  - One `done` pulse per grant.
- Withdrawal: `req`=0101, port 0 owns, `req[0]` dropped after 2 cycles.
  - Next edge: `owner`=2.
  - No `done[0]` pulse.
  - Port 2 then gets a full 4 cycles.
- Live update and idle: owner 1 with value 0x12→0x7F mid-dwell.
  - `num`=0x7F one cycle later.
  - Drop all requests → `IDLE`, `num_valid`=0, `num`=0.
  - Then `req`=0011 → `owner`=2? No: the next winner is port 0, because the search starts at `ptr`=2 and wraps (ports 2 and 3 are not requesting).
